// File: rtl/spi_slave.sv
// SPI mode-0 responder: receives the 64-bit cmd/addr/data frame, exposes the fields on the
// host register bus, and returns a host-preloaded word on miso for read commands.
module spi_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic [31:0] write_data,
  input  logic        re,
  output logic [31:0] read_data,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        irq
);

  // state   | meaning
  // S_IDLE  | wait for armed and synchronized cs_n low
  // S_SHIFT | shift mosi in on each sclk rise until 64 bits or abort
  // S_DONE  | one clk: publish the captured fields, raise rx_valid
  // S_WAIT  | ignore sclk until cs_n deasserts
  localparam int FRAME_BITS = 64;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_WAIT} state_t;
  state_t state, state_nxt;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall;

  logic [6:0]  bit_cnt;
  logic [63:0] rx_shift;
  logic [31:0] tx_shift;
  logic        tx_active;
  logic        tx_latch;

  logic        armed;
  logic        cs_active;
  logic [7:0]  rx_cmd;
  logic [23:0] rx_addr;
  logic [31:0] rx_data;
  logic [31:0] tx_data;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic [31:0] rd_mux;
  logic        status_we;

  logic start, shift_en, load_rx, abort;

  // Synchronizers carry no reset so they keep tracking the pins through a reset pulse.
  always_ff @(posedge clk) begin
    sclk_s1 <= sclk;
    sclk_s2 <= sclk_s1;
    sclk_s3 <= sclk_s2;
    cs_s1   <= cs_n;
    cs_s2   <= cs_s1;
    mosi_s1 <= mosi;
    mosi_s2 <= mosi_s1;
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    load_rx   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && !cs_s2) begin
          start     = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == 7'(FRAME_BITS)) begin
          state_nxt = S_DONE;
        end else if (cs_s2) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      S_DONE: begin
        load_rx   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cs_s2) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 7'd0;
      rx_shift <= 64'd0;
    end else if (start) begin
      bit_cnt  <= 7'd0;
      rx_shift <= 64'd0;
    end else if (shift_en) begin
      rx_shift <= {rx_shift[62:0], mosi_s2};
      bit_cnt  <= bit_cnt + 7'd1;
    end
  end

  // After 32 bits the command byte sits in rx_shift[31:24]; bit 31 flags a read.
  assign tx_latch = (state == S_SHIFT) && sclk_fall && (bit_cnt == 7'd32) && rx_shift[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_active <= 1'b0;
      tx_shift  <= 32'd0;
      miso      <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        tx_active <= 1'b0;
        tx_shift  <= 32'd0;
      end else if (tx_latch) begin
        tx_active <= 1'b1;
        tx_shift  <= tx_data;
      end else if (tx_active && sclk_fall) begin
        tx_shift <= {tx_shift[30:0], 1'b0};
      end
      miso <= tx_active & tx_shift[31];
    end
  end

  assign status_we = we && (addr == 3'd0);

  always_comb begin
    rd_mux = 32'd0;
    case (addr)
      3'd0:    rd_mux = {28'd0, frame_err, overrun, cs_active, rx_valid};
      3'd1:    rd_mux = {24'd0, rx_cmd};
      3'd2:    rd_mux = {8'd0, rx_addr};
      3'd3:    rd_mux = rx_data;
      3'd4:    rd_mux = tx_data;
      default: rd_mux = 32'd0;
    endcase
  end

  // Hardware sets take priority over read-clear and W1C on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      cs_active <= 1'b0;
      rx_cmd    <= 8'd0;
      rx_addr   <= 24'd0;
      rx_data   <= 32'd0;
      tx_data   <= 32'd0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      read_data <= 32'd0;
    end else begin
      armed     <= armed | cs_s2;
      cs_active <= ~cs_s2;
      if (we && (addr == 3'd4)) tx_data <= write_data;
      if (load_rx) begin
        rx_cmd  <= rx_shift[63:56];
        rx_addr <= rx_shift[55:32];
        rx_data <= rx_shift[31:0];
      end
      rx_valid  <= load_rx | (rx_valid & ~(re && (addr == 3'd3)));
      overrun   <= (load_rx & rx_valid) | (overrun & ~(status_we & write_data[2]));
      frame_err <= abort | (frame_err & ~(status_we & write_data[3]));
      if (re) read_data <= rd_mux;
    end
  end

  assign miso_oe = cs_active;
  assign irq     = rx_valid;

endmodule
